alu_seq: RTL and testbench

- Issue sequencer and initiator for the core's combinational ALU.
- Accepts one operation request at a time through a valid/ready handshake, decodes the opcode to the 5-bit ALU code and selects the operands.
- Holds the ALU inputs stable for the op's latency: 1 cycle for simple ops, MULDIV_CYCLES for mult/div, which are declared multicycle paths.
- Captures the ALU result and zero flag, then returns result, branch decision and illegal flag through a valid/ready response.

---
 rtl/alu_seq_pkg.sv | 56 +++++
 rtl/alu_seq_decode.sv | 70 +++++++
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants and types for the ALU issue sequencer.
// Holds the ALU code map, the opcode map, FSM/branch enums and operand
// extension helpers used by alu_seq and alu_seq_decode.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned CNT_W  = 4;

  // ALU function codes driven onto the ALU opcode input
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_PAS1 = 5'd2;
  localparam logic [4:0] ALU_MUL  = 5'd3;
  localparam logic [4:0] ALU_DIV  = 5'd4;
  localparam logic [4:0] ALU_PAS2 = 5'd5;
  localparam logic [4:0] ALU_LE   = 5'd6;
  localparam logic [4:0] ALU_GE   = 5'd7;

  // Request opcodes; everything above OP_STORE is illegal
  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_MOV   = 6'h02;
  localparam logic [5:0] OP_MUL   = 6'h03;
  localparam logic [5:0] OP_DIV   = 6'h04;
  localparam logic [5:0] OP_LOADI = 6'h05;
  localparam logic [5:0] OP_SLT   = 6'h06;
  localparam logic [5:0] OP_SGT   = 6'h07;
  localparam logic [5:0] OP_BEQ   = 6'h08;
  localparam logic [5:0] OP_BNE   = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0A;
  localparam logic [5:0] OP_SUBI  = 6'h0B;
  localparam logic [5:0] OP_LOAD  = 6'h0C;
  localparam logic [5:0] OP_STORE = 6'h0D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2
  } branch_e;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational opcode decode for the ALU sequencer.
// Maps a request opcode to the ALU code, operand selection, multicycle flag,
// branch type and illegal flag.
// Optional macro ALU_SEQ_DIVZ_TRAP_EN: when defined, DIV with a zero divisor
// is reported illegal instead of being issued.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [5:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic [4:0]        alu_code_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic              multicycle_o,
  output branch_e           branch_o,
  output logic              illegal_o
);

  // Opcode table: every output gets a default, then per-op overrides
  always_comb begin
    alu_code_o   = ALU_ADD;
    data1_o      = a_i;
    data2_o      = b_i;
    multicycle_o = 1'b0;
    branch_o     = BR_NONE;
    illegal_o    = 1'b0;
    case (op_i)
      OP_ADD:   alu_code_o = ALU_ADD;
      OP_SUB:   alu_code_o = ALU_SUB;
      OP_MOV:   alu_code_o = ALU_PAS1;
      OP_MUL: begin
        alu_code_o   = ALU_MUL;
        multicycle_o = 1'b1;
      end
      OP_DIV: begin
        alu_code_o   = ALU_DIV;
        multicycle_o = 1'b1;
`ifdef ALU_SEQ_DIVZ_TRAP_EN
        illegal_o    = (b_i == '0);
`endif
      end
      OP_LOADI: begin
        alu_code_o = ALU_PAS2;
        data2_o    = zext_imm(imm_i);
      end
      OP_SLT:   alu_code_o = ALU_LE;
      OP_SGT:   alu_code_o = ALU_GE;
      OP_BEQ: begin
        alu_code_o = ALU_SUB;
        branch_o   = BR_EQ;
      end
      OP_BNE: begin
        alu_code_o = ALU_SUB;
        branch_o   = BR_NE;
      end
      OP_ADDI, OP_LOAD, OP_STORE: begin
        alu_code_o = ALU_ADD;
        data2_o    = sext_imm(imm_i);
      end
      OP_SUBI: begin
        alu_code_o = ALU_SUB;
        data2_o    = sext_imm(imm_i);
      end
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: issue sequencer for the external combinational ALU.
// Accepts one request (valid/ready), drives registered ALU inputs for the
// op's latency (MULDIV_CYCLES for MUL/DIV, which are multicycle paths),
// captures the result and returns it through a valid/ready response.
// Optional macro ALU_SEQ_DIVZ_TRAP_EN (handled in alu_seq_decode) traps
// DIV by zero as an illegal op.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [15:0] req_imm,
  output logic [4:0]  alu_code,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_branch_taken,
  output logic        rsp_illegal
);

  // Counter preload so EXEC lasts exactly MULDIV_CYCLES cycles for MUL/DIV
  localparam logic [CNT_W-1:0] CNT_MC = CNT_W'(MULDIV_CYCLES - 1);

  logic [4:0]        dec_code;
  logic [DATA_W-1:0] dec_data1;
  logic [DATA_W-1:0] dec_data2;
  logic              dec_mc;
  branch_e           dec_branch;
  logic              dec_illegal;

  state_e            state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  branch_e           branch_q, branch_d;
  logic [4:0]        code_q,   code_d;
  logic [DATA_W-1:0] data1_q,  data1_d;
  logic [DATA_W-1:0] data2_q,  data2_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              taken_q,  taken_d;
  logic              illegal_q, illegal_d;

  alu_seq_decode u_decode (
    .op_i         (req_op),
    .a_i          (req_a),
    .b_i          (req_b),
    .imm_i        (req_imm),
    .alu_code_o   (dec_code),
    .data1_o      (dec_data1),
    .data2_o      (dec_data2),
    .multicycle_o (dec_mc),
    .branch_o     (dec_branch),
    .illegal_o    (dec_illegal)
  );

  // Next-state logic: accept in IDLE, count down in EXEC, hand off in RESP
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    branch_d  = branch_q;
    code_d    = code_q;
    data1_d   = data1_q;
    data2_d   = data2_q;
    result_d  = result_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (dec_illegal) begin
            // Illegal ops never reach the ALU; its inputs keep old values
            result_d  = '0;
            taken_d   = 1'b0;
            illegal_d = 1'b1;
            state_d   = RESP;
          end else begin
            code_d   = dec_code;
            data1_d  = dec_data1;
            data2_d  = dec_data2;
            branch_d = dec_branch;
            cnt_d    = dec_mc ? CNT_MC : '0;
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          result_d  = alu_result;
          illegal_d = 1'b0;
          case (branch_q)
            BR_EQ:   taken_d = alu_zero;
            BR_NE:   taken_d = !alu_zero;
            default: taken_d = 1'b0;
          endcase
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; async reset abandons any op in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      branch_q  <= BR_NONE;
      code_q    <= '0;
      data1_q   <= '0;
      data2_q   <= '0;
      result_q  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      branch_q  <= branch_d;
      code_q    <= code_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      result_q  <= result_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign rsp_valid        = (state_q == RESP);
  assign alu_code         = code_q;
  assign alu_data1        = data1_q;
  assign alu_data2        = data2_q;
  assign rsp_result       = result_q;
  assign rsp_branch_taken = taken_q;
  assign rsp_illegal      = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with a behavioural ALU model and
// a response scoreboard.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [15:0] req_imm;
  logic [4:0]  alu_code;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_branch_taken;
  logic        rsp_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        taken;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  logic [4:0]  last_code;
  logic [31:0] last_d1;
  logic [31:0] last_d2;

  alu_seq #(.MULDIV_CYCLES(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_a            (req_a),
    .req_b            (req_b),
    .req_imm          (req_imm),
    .alu_code         (alu_code),
    .alu_data1        (alu_data1),
    .alu_data2        (alu_data2),
    .alu_result       (alu_result),
    .alu_zero         (alu_zero),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_result       (rsp_result),
    .rsp_branch_taken (rsp_branch_taken),
    .rsp_illegal      (rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU sitting outside the sequencer
  always_comb begin
    alu_result = 32'h0;
    case (alu_code)
      5'd0: alu_result = alu_data1 + alu_data2;
      5'd1: alu_result = alu_data1 - alu_data2;
      5'd2: alu_result = alu_data1;
      5'd3: alu_result = alu_data1 * alu_data2;
      5'd4: alu_result = alu_data1 / ((alu_data2 == 32'h0) ? 32'h1 : alu_data2);
      5'd5: alu_result = alu_data2;
      5'd6: alu_result = {31'h0, $signed(alu_data1) <= $signed(alu_data2)};
      5'd7: alu_result = {31'h0, $signed(alu_data1) >= $signed(alu_data2)};
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request, track latency and ALU-input stability, compare the
  // response against the scoreboard, optionally stall, then retire it.
  task automatic issue(input string name, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm, input logic [4:0] ecode,
                       input logic [31:0] ed2, input logic [31:0] eres,
                       input logic etaken, input logic eill,
                       input int elat, input int hold);
    exp_t e;
    int lat;
    e.res = eres; e.taken = etaken; e.ill = eill;
    chk({name, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    req_op = op; req_a = a; req_b = b; req_imm = imm;
    req_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    if (!eill) begin
      last_code = ecode; last_d1 = a; last_d2 = ed2;
    end
    chk({name, "_alu_code"}, {27'h0, alu_code}, {27'h0, last_code});
    chk({name, "_alu_data1"}, alu_data1, last_d1);
    chk({name, "_alu_data2"}, alu_data2, last_d2);
    while (!rsp_valid && lat < 40) begin
      chk({name, "_hold_code"}, {27'h0, alu_code}, {27'h0, last_code});
      chk({name, "_hold_d1"}, alu_data1, last_d1);
      chk({name, "_hold_d2"}, alu_data2, last_d2);
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, elat);
    if (sb.size() > 0) e = sb.pop_front();
    chk({name, "_result"}, rsp_result, e.res);
    chk({name, "_taken"}, {31'h0, rsp_branch_taken}, {31'h0, e.taken});
    chk({name, "_illegal"}, {31'h0, rsp_illegal}, {31'h0, e.ill});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_stall_valid"}, {31'h0, rsp_valid}, 32'h1);
      chk({name, "_stall_ready"}, {31'h0, req_ready}, 32'h0);
      chk({name, "_stall_result"}, rsp_result, e.res);
      chk({name, "_stall_illegal"}, {31'h0, rsp_illegal}, {31'h0, e.ill});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({name, "_retire_valid"}, {31'h0, rsp_valid}, 32'h0);
    chk({name, "_retire_ready"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 6'h0; req_a = 32'h0; req_b = 32'h0; req_imm = 16'h0;
    last_code = 5'h0; last_d1 = 32'h0; last_d2 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_alu_code", {27'h0, alu_code}, 32'h0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    issue("add",   6'h00, 32'd5,  32'd7, 16'h0000, 5'd0, 32'd7,      32'd12,         1'b0, 1'b0, 2, 0);
    issue("addi",  6'h0A, 32'd10, 32'd0, 16'hFFFF, 5'd0, 32'hFFFFFFFF, 32'd9,       1'b0, 1'b0, 2, 0);
    issue("subi",  6'h0B, 32'd10, 32'd0, 16'h0002, 5'd1, 32'd2,      32'd8,          1'b0, 1'b0, 2, 0);
    issue("loadi", 6'h05, 32'd1,  32'd0, 16'h8001, 5'd5, 32'h00008001, 32'h00008001, 1'b0, 1'b0, 2, 0);
    issue("store", 6'h0D, 32'd100, 32'd0, 16'hFFFC, 5'd0, 32'hFFFFFFFC, 32'd96,     1'b0, 1'b0, 2, 0);
    issue("mov",   6'h02, 32'hABCD, 32'd1, 16'h0, 5'd2, 32'd1,       32'hABCD,       1'b0, 1'b0, 2, 0);
    issue("mul",   6'h03, 32'd6,  32'd7, 16'h0, 5'd3, 32'd7,         32'd42,         1'b0, 1'b0, 5, 0);
    issue("div",   6'h04, 32'd20, 32'd3, 16'h0, 5'd4, 32'd3,         32'd6,          1'b0, 1'b0, 5, 0);
    issue("beq",   6'h08, 32'd3,  32'd3, 16'h0, 5'd1, 32'd3,         32'd0,          1'b1, 1'b0, 2, 0);
    issue("bne_eq", 6'h09, 32'd3, 32'd3, 16'h0, 5'd1, 32'd3,         32'd0,          1'b0, 1'b0, 2, 0);
    issue("bne_ne", 6'h09, 32'd3, 32'd4, 16'h0, 5'd1, 32'd4,         32'hFFFFFFFF,   1'b1, 1'b0, 2, 0);
    issue("slt",   6'h06, 32'd2,  32'd2, 16'h0, 5'd6, 32'd2,         32'd1,          1'b0, 1'b0, 2, 0);
    issue("sgt",   6'h07, 32'd5,  32'd3, 16'h0, 5'd7, 32'd3,         32'd1,          1'b0, 1'b0, 2, 1);
    issue("ill20", 6'h20, 32'd1,  32'd2, 16'h0, 5'd0, 32'd0,         32'd0,          1'b0, 1'b1, 1, 0);
    issue("ill0e", 6'h0E, 32'd1,  32'd2, 16'h0, 5'd0, 32'd0,         32'd0,          1'b0, 1'b1, 1, 0);
    issue("ill3f", 6'h3F, 32'd1,  32'd2, 16'h0, 5'd0, 32'd0,         32'd0,          1'b0, 1'b1, 1, 0);
`ifdef ALU_SEQ_DIVZ_TRAP_EN
    issue("divz",  6'h04, 32'd9,  32'd0, 16'h0, 5'd4, 32'd0,         32'd0,          1'b0, 1'b1, 1, 3);
`else
    issue("divz",  6'h04, 32'd9,  32'd0, 16'h0, 5'd4, 32'd0,         32'd9,          1'b0, 1'b0, 5, 3);
`endif

    // Reset in the second EXEC cycle of a MUL: the op must vanish
    req_op = 6'h03; req_a = 32'd6; req_b = 32'd7; req_imm = 16'h0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmul_alu_code", {27'h0, alu_code}, 32'h0);
    chk("rstmul_alu_d1", alu_data1, 32'h0);
    chk("rstmul_alu_d2", alu_data2, 32'h0);
    chk("rstmul_result", rsp_result, 32'h0);
    chk("rstmul_taken", {31'h0, rsp_branch_taken}, 32'h0);
    chk("rstmul_illegal", {31'h0, rsp_illegal}, 32'h0);
    chk("rstmul_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rstmul_req_ready", {31'h0, req_ready}, 32'h1);
    last_code = 5'h0; last_d1 = 32'h0; last_d2 = 32'h0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("rstmul_no_rsp", {31'h0, rsp_valid}, 32'h0);
      chk("rstmul_ready", {31'h0, req_ready}, 32'h1);
    end

    issue("add_after_rst", 6'h00, 32'hFFFFFFFF, 32'd2, 16'h0, 5'd0, 32'd2, 32'd1, 1'b0, 1'b0, 2, 0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
